nios_wallet_po_handshake: RTL
=============================

Name: nios_wallet_po_handshake

Overview:
- Avalon-MM slave output port for the Nios wallet system.
- It is the write-side counterpart of the read-only input PIO: the CPU loads a word that is driven on out_port toward fabric logic.
- Each word loaded through the DATA register is announced with a valid/ack handshake. out_port is held stable until the consumer acknowledges it.
- Software sees pending, overflow and a transfer count through a status register.

Parameters:
- DATA_WIDTH, 32, width of out_port and the data register (1..32).
- RESET_VALUE, 0, value loaded into the data register at reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  reset. Asynchronous assert, active-low; release synchronous to clk upstream.
- address  input  2  word address. 0=DATA, 1=STATUS, 2=SET, 3=CLEAR.
- chipselect  input  1  slave select; qualifies write_n.
- write_n  input  1  active-low write strobe. A write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  DATA_WIDTH  current data register value.
- out_valid  output  1  high while a DATA word awaits acknowledgement.
- out_ack  input  1  consumer acknowledge; sampled only while out_valid=1.

Behaviour:
- Reset (reset_n=0, immediate): readdata=0, data_reg=RESET_VALUE, pending=0, overflow=0, xfer_count=0.
  - Hence out_port=RESET_VALUE and out_valid=0.
  - Reset mid-handshake discards the pending word; no ack is required afterwards.
- Direct outputs: out_valid = pending and out_port = data_reg, both driven straight from registers with no combinational path from bus inputs.
- Read path:
  - readdata is registered every cycle from a mux on address, independent of chipselect.
  - Read latency is 1 cycle. Reads have no side effects.
  - DATA reads data_reg zero-extended to 32 bits.
  - STATUS reads {xfer_count[15:0], 13'b0, overflow, 1'b0, pending}.
  - SET and CLEAR read 0.
- Write, DATA (addr 0):
  - If pending=0: data_reg <= writedata[DATA_WIDTH-1:0] and pending <= 1. out_valid rises the cycle after the write.
  - If pending=1 and out_ack=0: the write is dropped and overflow <= 1 (sticky).
  - If pending=1 and out_ack=1 in the same cycle: the ack completes the old word (xfer_count increments) and the new write is accepted. pending stays 1, data_reg takes the new value, overflow is unchanged.
- Write, STATUS (addr 1): writedata[2]=1 clears overflow (write-1-to-clear). All other bits are ignored. pending and xfer_count are not writable.
- Write, SET (addr 2) and CLEAR (addr 3): bit-level control without a handshake.
  - SET: data_reg <= data_reg | writedata[DATA_WIDTH-1:0].
  - CLEAR: data_reg <= data_reg & ~writedata[DATA_WIDTH-1:0].
  - Neither changes pending.
  - If pending=1 and out_ack=0: the write is dropped and overflow <= 1, so out_port stays stable while valid.
  - If pending=1 and out_ack=1 in the same cycle: the write is applied and pending clears.
- Handshake:
  - When pending=1 and out_ack=1, then next edge: pending <= 0 (unless a same-cycle DATA write re-arms it) and xfer_count <= xfer_count+1.
  - xfer_count is 16 bits and wraps from 0xFFFF to 0x0000.
  - out_ack while pending=0 is ignored; there is no count change.
- Overflow priority: a STATUS W1C and a dropped write cannot coincide, since there is one write per cycle.
- Writedata bits above DATA_WIDTH are ignored. Writes with chipselect=0 are ignored.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with pending=1 -> out_valid=0, out_port=RESET_VALUE, STATUS reads 0x00000000 immediately after release.
- Basic transfer: write DATA=0xA5A5_1234 -> next cycle out_valid=1, out_port=0xA5A51234. Pulse out_ack one cycle -> out_valid=0, STATUS=0x0001_0000, DATA read returns 0xA5A51234 one cycle after address is applied.
- Overflow: write DATA=0x11, hold out_ack=0, write DATA=0x22 and SET=0xF0 -> out_port stays 0x11, STATUS=0x0000_0005. Write STATUS=0x4 -> STATUS=0x0000_0001.
- Simultaneous ack+write: with pending on 0x11, write DATA=0x33 in the same cycle out_ack=1 -> out_valid stays 1, out_port=0x33, overflow=0, xfer_count=1.
- Set/clear idle: data_reg=0x0000_00FF, SET=0x0F00 -> 0x0FFF; CLEAR=0x00F0 -> 0x0F0F. out_valid stays 0 throughout, and a stray out_ack leaves the count unchanged.
- Count wrap: complete 65536 DATA/ack transfers -> STATUS[31:16]=0x0000, no overflow.

Source files
------------

// File: rtl/nios_wallet_po_handshake_if.sv
// Bus and handshake bundle for the wallet output port: Avalon-MM slave
// signals toward the CPU plus the valid/ack pair toward fabric logic.
interface nios_wallet_po_handshake_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic [DATA_WIDTH-1:0] out_port;
    logic                  out_valid;
    logic                  out_ack;

    // Environment side: CPU bus master plus the downstream consumer
    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  out_port,
        input  out_valid,
        output out_ack
    );

    // Peripheral side
    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output out_port,
        output out_valid,
        input  out_ack
    );
endinterface

// File: rtl/nios_wallet_po_handshake.sv
// Avalon-MM output port for the Nios wallet system. A DATA write loads the
// output word and raises out_valid; the word stays frozen on out_port until
// the consumer acknowledges it. SET/CLEAR give bit-level control, and a
// STATUS register exposes pending, a sticky overflow flag and a 16-bit
// transfer count.
module nios_wallet_po_handshake #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    nios_wallet_po_handshake_if.slave   bus
);

    localparam logic [DATA_WIDTH-1:0] RESET_DATA = RESET_VALUE[DATA_WIDTH-1:0];

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_SET    = 2'd2;
    localparam logic [1:0] ADDR_CLEAR  = 2'd3;

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_pending;
    logic                  r_overflow;
    logic [15:0]           r_xferCount;
    logic [31:0]           r_readData;

    logic [DATA_WIDTH-1:0] w_nextData;
    logic                  w_nextPending;
    logic                  w_nextOverflow;
    logic [15:0]           w_nextCount;
    logic [31:0]           w_readMux;
    logic [DATA_WIDTH-1:0] w_writeBits;
    logic                  w_write;
    logic                  w_ackFire;
    logic                  w_blocked;

    assign w_write     = bus.chipselect & ~bus.write_n;
    assign w_writeBits = bus.writedata[DATA_WIDTH-1:0];
    assign w_ackFire   = r_pending & bus.out_ack;
    assign w_blocked   = r_pending & ~bus.out_ack;

    // Next-state for the data word, handshake flag, overflow and transfer count;
    // an ack in the same cycle frees the slot so a write can land immediately
    always_comb begin
        w_nextData     = r_data;
        w_nextPending  = r_pending;
        w_nextOverflow = r_overflow;
        w_nextCount    = r_xferCount;

        if (w_ackFire) begin
            w_nextPending = 1'b0;
            w_nextCount   = r_xferCount + 16'd1;
        end

        if (w_write) begin
            case (bus.address)
                ADDR_DATA: begin
                    if (w_blocked) begin
                        w_nextOverflow = 1'b1;
                    end else begin
                        w_nextData    = w_writeBits;
                        w_nextPending = 1'b1;
                    end
                end
                ADDR_STATUS: begin
                    if (bus.writedata[2]) begin
                        w_nextOverflow = 1'b0;
                    end
                end
                ADDR_SET: begin
                    if (w_blocked) begin
                        w_nextOverflow = 1'b1;
                    end else begin
                        w_nextData = r_data | w_writeBits;
                    end
                end
                default: begin
                    if (w_blocked) begin
                        w_nextOverflow = 1'b1;
                    end else begin
                        w_nextData = r_data & ~w_writeBits;
                    end
                end
            endcase
        end
    end

    // Read mux, evaluated every cycle regardless of chipselect
    always_comb begin
        w_readMux = 32'h0;
        case (bus.address)
            ADDR_DATA:   w_readMux = 32'(r_data);
            ADDR_STATUS: w_readMux = {r_xferCount, 13'b0, r_overflow, 1'b0, r_pending};
            default:     w_readMux = 32'h0;
        endcase
    end

    // State and read-data registers; reset drops any word awaiting ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= RESET_DATA;
            r_pending   <= 1'b0;
            r_overflow  <= 1'b0;
            r_xferCount <= 16'h0;
            r_readData  <= 32'h0;
        end else begin
            r_data      <= w_nextData;
            r_pending   <= w_nextPending;
            r_overflow  <= w_nextOverflow;
            r_xferCount <= w_nextCount;
            r_readData  <= w_readMux;
        end
    end

    assign bus.readdata  = r_readData;
    assign bus.out_port  = r_data;
    assign bus.out_valid = r_pending;

endmodule
